// File: rtl/axil_cmd_master.sv
// axil_cmd_master: single-outstanding command/response to AXI4-Lite master bridge.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to build the sticky slave-wait timeout flag.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
module axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_write,
  input  logic [`AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [`AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [`AXI_STROBE_WIDTH-1:0] cmd_wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_write,
  output logic [`AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [`AXI_RESP_WIDTH-1:0]   rsp_resp,
  output logic                         M_AXI_AWVALID,
  input  logic                         M_AXI_AWREADY,
  output logic [`AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                   M_AXI_AWPROT,
  output logic                         M_AXI_WVALID,
  input  logic                         M_AXI_WREADY,
  output logic [`AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [`AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB,
  input  logic                         M_AXI_BVALID,
  output logic                         M_AXI_BREADY,
  input  logic [`AXI_RESP_WIDTH-1:0]   M_AXI_BRESP,
  output logic                         M_AXI_ARVALID,
  input  logic                         M_AXI_ARREADY,
  output logic [`AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                   M_AXI_ARPROT,
  input  logic                         M_AXI_RVALID,
  output logic                         M_AXI_RREADY,
  input  logic [`AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [`AXI_RESP_WIDTH-1:0]   M_AXI_RRESP,
  output logic                         busy,
  output logic                         timeout
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;
  state_t state;
  logic [`AXI_ADDR_WIDTH-1:0] addr_q;
  logic aw_done, w_done, aw_hs, w_hs;
  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs = M_AXI_WVALID & M_AXI_WREADY;
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      addr_q <= '0;
      M_AXI_WDATA <= '0;
      M_AXI_WSTRB <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr_q <= cmd_addr;
            M_AXI_WDATA <= cmd_wdata;
            M_AXI_WSTRB <= cmd_wstrb;
            rsp_write <= cmd_write;
            cmd_ready <= 1'b0;
            busy <= 1'b1;
            state <= cmd_write ? WRITE : RADDR;
            M_AXI_AWVALID <= cmd_write;
            M_AXI_WVALID <= cmd_write;
            M_AXI_ARVALID <= !cmd_write;
          end
        end
        WRITE: begin
          if (aw_hs) begin
            M_AXI_AWVALID <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            M_AXI_WVALID <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done <= 1'b0;
            M_AXI_BREADY <= 1'b1;
            state <= WRESP;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID && M_AXI_BREADY) begin
            M_AXI_BREADY <= 1'b0;
            rsp_resp <= M_AXI_BRESP;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RADDR: begin
          if (M_AXI_ARVALID && M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY <= 1'b1;
            state <= RDATA;
          end
        end
        RDATA: begin
          if (M_AXI_RVALID && M_AXI_RREADY) begin
            M_AXI_RREADY <= 1'b0;
            rsp_rdata <= M_AXI_RDATA;
            rsp_resp <= M_AXI_RRESP;
            rsp_valid <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy <= 1'b0;
            cmd_ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic waiting;
  assign waiting = state inside {WRITE, WRESP, RADDR, RDATA};
  // Counter saturates so a very long stall cannot wrap; the flag itself is sticky.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= (state == IDLE) ? '0 : (!waiting || cnt == CW'(TIMEOUT_CYCLES)) ? cnt : cnt + 1'b1;
      if (waiting && cnt == CW'(TIMEOUT_CYCLES - 1)) timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed checks of axil_cmd_master against a latency-programmable AXI4-Lite slave.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_STROBE_WIDTH
`define AXI_STROBE_WIDTH 4
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
module tb_axil_cmd_master;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [`AXI_ADDR_WIDTH-1:0] cmd_addr = '0;
  logic [`AXI_DATA_WIDTH-1:0] cmd_wdata = '0;
  logic [`AXI_STROBE_WIDTH-1:0] cmd_wstrb = '0;
  logic cmd_ready, rsp_valid, rsp_write, busy, timeout;
  logic [`AXI_DATA_WIDTH-1:0] rsp_rdata;
  logic [`AXI_RESP_WIDTH-1:0] rsp_resp;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [`AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [`AXI_DATA_WIDTH-1:0] wdata, s_rdata;
  logic [`AXI_STROBE_WIDTH-1:0] wstrb;
  logic [`AXI_RESP_WIDTH-1:0] s_rresp;
  int aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic [`AXI_RESP_WIDTH-1:0] bresp_v = '0, rresp_v = '0;
  logic [`AXI_DATA_WIDTH-1:0] rdata_v = '0;
  int n_chk = 0, n_fail = 0;

  always #5 CLK = ~CLK;

  axil_cmd_master #(
`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    .TIMEOUT_CYCLES(16)
`else
    .TIMEOUT_CYCLES(1024)
`endif
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp_v),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp),
    .busy(busy), .timeout(timeout)
  );

  // Slave: each READY rises once its VALID has waited the programmed number of cycles.
  int aw_wait, w_wait, ar_wait;
  logic aw_seen, w_seen;
  assign awready = awvalid && (aw_wait >= aw_lat);
  assign wready = wvalid && (w_wait >= w_lat);
  assign arready = arvalid && (ar_wait >= ar_lat);
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
      w_wait <= (wvalid && !wready) ? w_wait + 1 : 0;
      ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
      if (awvalid && awready) aw_seen <= 1'b1;
      if (wvalid && wready) w_seen <= 1'b1;
      if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready)) && !bvalid) begin
        bvalid <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; s_rdata <= rdata_v; s_rresp <= rresp_v;
      end else if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // Monitor: handshake cycle stamps, captures and monotonic event counters.
  int cyc = 0, n_acc = 0, n_rsp = 0, n_b = 0, n_aw_hi = 0, n_w_hi = 0, n_unstable = 0;
  int acc_cyc, aw_cyc, w_cyc, b_cyc, ar_cyc, r_cyc, rsp_cyc;
  logic [31:0] c_awaddr, c_wdata, c_wstrb, c_araddr, c_rdata, c_resp, c_write;
  logic prev_aw_pend = 1'b0;
  logic [`AXI_ADDR_WIDTH-1:0] prev_awaddr = '0;
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin n_acc <= n_acc + 1; acc_cyc <= cyc; end
    if (awvalid) n_aw_hi <= n_aw_hi + 1;
    if (wvalid) n_w_hi <= n_w_hi + 1;
    if (awvalid && awready) begin aw_cyc <= cyc; c_awaddr <= 32'(awaddr); end
    if (wvalid && wready) begin w_cyc <= cyc; c_wdata <= 32'(wdata); c_wstrb <= 32'(wstrb); end
    if (bvalid && bready) begin n_b <= n_b + 1; b_cyc <= cyc; end
    if (arvalid && arready) begin ar_cyc <= cyc; c_araddr <= 32'(araddr); end
    if (rvalid && rready) r_cyc <= cyc;
    if (rsp_valid && rsp_ready) begin
      n_rsp <= n_rsp + 1; rsp_cyc <= cyc;
      c_rdata <= 32'(rsp_rdata); c_resp <= 32'(rsp_resp); c_write <= 32'(rsp_write);
    end
    if (!RST && prev_aw_pend && (!awvalid || awaddr != prev_awaddr)) n_unstable <= n_unstable + 1;
    prev_aw_pend <= awvalid && !awready;
    prev_awaddr <= awaddr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 50 && !cmd_ready; i++) @(negedge CLK);
    chk("cmd_accept_ready", 32'(cmd_ready), 1);
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int base;
    base = n_rsp;
    for (int i = 0; i < 100 && n_rsp == base; i++) @(negedge CLK);
    chk(tag, n_rsp, base + 1);
  endtask

  initial begin
    int base_b, base_aw, base_w, base_acc, base_rsp;
    #1 RST = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, rsp_valid}, 0);
    chk("rst_readys", {30'd0, bready, rready}, 0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
    chk("rst_timeout", 32'(timeout), 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_hold_cmd_ready", 32'(cmd_ready), 0);
    @(negedge CLK);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 1);
    chk("prot", {26'd0, awprot, arprot}, 0);

    // Write to an always-ready slave
    send(1'b1, 32'h0204, 32'hDEADBEEF, 4'b1111);
    wait_rsp("wr_rsp");
    chk("wr_awaddr", c_awaddr, 32'h0204);
    chk("wr_wdata", c_wdata, 32'hDEADBEEF);
    chk("wr_wstrb", c_wstrb, 32'hF);
    chk("wr_aw_lat", aw_cyc - acc_cyc, 1);
    chk("wr_w_lat", w_cyc - acc_cyc, 1);
    chk("wr_b_lat", b_cyc - acc_cyc, 2);
    chk("wr_rsp_lat", rsp_cyc - acc_cyc, 3);
    chk("wr_resp", c_resp, 0);
    chk("wr_rsp_write", c_write, 1);
    chk("wr_rsp_rdata", c_rdata, 0);
    @(negedge CLK);
    chk("wr_idle_busy", 32'(busy), 0);
    chk("wr_idle_cmd_ready", 32'(cmd_ready), 1);

    // Read returning DEADBEEF
    rdata_v = 32'hDEADBEEF;
    send(1'b0, 32'h0204, 32'h0, 4'h0);
    wait_rsp("rd_rsp");
    chk("rd_araddr", c_araddr, 32'h0204);
    chk("rd_rdata", c_rdata, 32'hDEADBEEF);
    chk("rd_resp", c_resp, 0);
    chk("rd_rsp_write", c_write, 0);
    chk("rd_ar_lat", ar_cyc - acc_cyc, 1);
    chk("rd_r_lat", r_cyc - acc_cyc, 2);
    chk("rd_rsp_lat", rsp_cyc - acc_cyc, 3);

    // Write with AWREADY delayed 3 cycles, WREADY immediate
    aw_lat = 3;
    base_b = n_b; base_aw = n_aw_hi; base_w = n_w_hi;
    send(1'b1, 32'h0103, 32'hA5A5_0103, 4'b0011);
    wait_rsp("slow_aw_rsp");
    chk("slow_aw_hi_cycles", n_aw_hi - base_aw, 4);
    chk("slow_w_hi_cycles", n_w_hi - base_w, 1);
    chk("slow_aw_lat", aw_cyc - acc_cyc, 4);
    chk("slow_w_lat", w_cyc - acc_cyc, 1);
    chk("slow_b_count", n_b - base_b, 1);
    chk("slow_rsp_lat", rsp_cyc - acc_cyc, 6);
    chk("slow_awaddr", c_awaddr, 32'h0103);
    chk("aw_stable", n_unstable, 0);
    chk("slow_resp", c_resp, 0);
    aw_lat = 0;

    // DECERR passes through on a write
    bresp_v = 2'b11;
    send(1'b1, 32'h0010, 32'h0000_1234, 4'b0101);
    wait_rsp("decerr_rsp");
    chk("decerr_resp", c_resp, 3);
    chk("decerr_wstrb", c_wstrb, 32'h5);
    bresp_v = 2'b00;

    // SLVERR read with rsp_ready held low
    rresp_v = 2'b10; rdata_v = 32'h0BAD_0300; rsp_ready = 1'b0;
    send(1'b0, 32'h0300, 32'h0, 4'h0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge CLK);
    chk("bp_rsp_valid_up", 32'(rsp_valid), 1);
    base_acc = n_acc;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0444;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_rsp_valid_hold", 32'(rsp_valid), 1);
      chk("bp_cmd_ready_low", 32'(cmd_ready), 0);
      chk("bp_rsp_resp_stable", 32'(rsp_resp), 2);
    end
    chk("bp_no_accept", n_acc, base_acc);
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    wait_rsp("bp_rsp");
    chk("bp_resp", c_resp, 2);
    chk("bp_rdata", c_rdata, 32'h0BAD_0300);
    rresp_v = 2'b00;
    chk("no_timeout", 32'(timeout), 0);

    // Reset during a pending AW
    aw_lat = 100;
    base_rsp = n_rsp;
    send(1'b1, 32'h0040, 32'h1111_2222, 4'hF);
    chk("mid_awvalid", 32'(awvalid), 1);
    chk("mid_busy", 32'(busy), 1);
    #2 RST = 1'b1;
    #1;
    chk("abort_valids", {30'd0, awvalid, wvalid}, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_cmd_ready", 32'(cmd_ready), 0);
    @(negedge CLK);
    RST = 1'b0; aw_lat = 0;
    @(negedge CLK);
    chk("abort_release_cmd_ready", 32'(cmd_ready), 1);
    repeat (5) @(negedge CLK);
    chk("abort_no_rsp", n_rsp, base_rsp);
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    rdata_v = 32'h1234_5678;
    send(1'b0, 32'h0008, 32'h0, 4'h0);
    wait_rsp("recover_rsp");
    chk("recover_rdata", c_rdata, 32'h1234_5678);

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
    // ARREADY withheld for 20 cycles against a 16-cycle limit
    ar_lat = 20; rdata_v = 32'h0000_00AA;
    send(1'b0, 32'h0500, 32'h0, 4'h0);
    repeat (15) @(negedge CLK);
    chk("to_before", 32'(timeout), 0);
    @(negedge CLK);
    chk("to_set", 32'(timeout), 1);
    wait_rsp("to_rsp");
    chk("to_rdata", c_rdata, 32'hAA);
    repeat (3) @(negedge CLK);
    chk("to_sticky", 32'(timeout), 1);
    RST = 1'b1;
    #1;
    chk("to_cleared", 32'(timeout), 0);
    @(negedge CLK);
    RST = 1'b0; ar_lat = 0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of cycles spent waiting on a slave handshake before the timeout flag sets.
REQ-002 SHALL have ports: CLK  in  1  sole clock, rising edge; RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in `AXI_ADDR_WIDTH; cmd_wdata in `AXI_DATA_WIDTH; cmd_wstrb in `AXI_STROBE_WIDTH.
REQ-004 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1 (echo of command type); rsp_rdata out `AXI_DATA_WIDTH; rsp_resp out `AXI_RESP_WIDTH.
REQ-005 SHALL have AXI4-Lite master ports M_AXI_AW{VALID,READY,ADDR,PROT}, M_AXI_W{VALID,READY,DATA,STRB}, M_AXI_B{VALID,READY,RESP}, M_AXI_AR{VALID,READY,ADDR,PROT}, M_AXI_R{VALID,READY,DATA,RESP}, with widths from the AXI configuration header.
REQ-006 SHALL have status ports: busy out 1 (high whenever the state is not IDLE); timeout out 1 (sticky flag).

Function
REQ-007 SHALL implement states IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
REQ-008 In IDLE, cmd_ready SHALL be 1; every other state SHALL hold cmd_ready at 0.
REQ-009 A cmd_valid&cmd_ready edge SHALL register addr, wdata, wstrb and type.
  - Write: next state WRITE.
  - Read: next state RADDR.
  - AWVALID/WVALID or ARVALID SHALL assert on the following cycle.
REQ-010 WRITE SHALL assert AWVALID and WVALID together and track aw_done and w_done independently.
  - Each VALID SHALL drop on the cycle after its own READY handshake.
  - Both handshakes may occur in the same cycle or in either order.
  - The state SHALL advance to WRESP once both are done.
REQ-011 WRESP SHALL hold BREADY=1; on the BVALID handshake it SHALL latch BRESP and go to RESP.
REQ-012 RADDR SHALL hold ARVALID until the ARREADY handshake, then go to RDATA.
REQ-013 RDATA SHALL hold RREADY=1; on the RVALID handshake it SHALL latch RDATA and RRESP and go to RESP.
REQ-014 RESP SHALL assert rsp_valid with stable rsp_* outputs until rsp_ready, then return to IDLE.
  - rsp_valid and cmd_ready SHALL never both be high.
REQ-015 For writes, rsp_rdata SHALL be 0.
REQ-016 AxVALID and ADDR/DATA/STRB SHALL stay stable while VALID is high and READY is low, per AXI4-Lite.
REQ-017 BREADY and RREADY SHALL be 0 outside WRESP and RDATA respectively.
REQ-018 AWPROT and ARPROT SHALL be constant 3'b000.
REQ-019 Latency with an always-ready slave and rsp_ready=1:
  - write: command accept at cycle N, AW/W handshake at N+1, B handshake at N+2, rsp_valid at N+3;
  - read: AR handshake at N+1, R handshake at N+2, rsp_valid at N+3.
REQ-020 Slave response codes (OKAY, SLVERR, DECERR) SHALL be passed through unmodified.

Reset
REQ-021 Asserting RST SHALL asynchronously set:
  - state to IDLE;
  - all M_AXI VALID/READY outputs, rsp_valid and busy to 0;
  - all data/address/strobe registers and rsp_* outputs to 0;
  - timeout to 0.
REQ-022 cmd_ready SHALL be 0 while RST is high and 1 on the first cycle after release.
REQ-023 Reset in the middle of a transaction SHALL drop every VALID immediately; the aborted command SHALL produce no response.

Configuration
REQ-024 With macro AXIL_CMD_MASTER_TIMEOUT_EN defined, a counter SHALL:
  - increment every cycle spent in WRITE, WRESP, RADDR or RDATA;
  - clear on entry to IDLE;
  - set timeout (held until RST) when it reaches TIMEOUT_CYCLES.
  The transaction SHALL continue unaltered.
REQ-025 Without AXIL_CMD_MASTER_TIMEOUT_EN, no counter SHALL be built and timeout SHALL be tied to 0.

Verification
REQ-026 Write cmd addr 0x0204, data 0xDEADBEEF, strb 4'b1111 to an always-ready slave -> AWADDR=0x0204, WDATA=0xDEADBEEF, WSTRB=4'b1111, rsp_valid at N+3 with rsp_resp=OKAY, rsp_write=1, rsp_rdata=0.
REQ-027 Read cmd addr 0x0204 with slave returning 0xDEADBEEF -> ARADDR=0x0204, rsp_rdata=0xDEADBEEF, rsp_resp=OKAY.
REQ-028 Write to 0x0103 with WREADY immediate and AWREADY delayed 3 cycles -> WVALID drops after 1 cycle, AWVALID holds 4 cycles with stable AWADDR, a single B handshake follows, then rsp_valid.
REQ-029 Read to 0x0300 with slave returning RRESP=SLVERR -> rsp_resp=SLVERR; with rsp_ready held low for 5 cycles, rsp_valid stays high, cmd_ready stays 0 and a new cmd_valid is not accepted.
REQ-030 RST pulsed while AWVALID=1 -> AWVALID, WVALID and busy are 0 in the same cycle, no rsp_valid appears, cmd_ready=1 after release.
REQ-031 With AXIL_CMD_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16 and a slave that withholds ARREADY for 20 cycles -> timeout rises after 16 wait cycles, the read then completes normally, and timeout stays 1 until RST.
